// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared state type and hold-counter width helper for priority_decoder_seq
package dec_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int CNT_W_MIN = 1;

  // Counter must represent HOLD_CYCLES-1 and never be zero-width.
  function automatic int cnt_width(input int hold_cycles);
    int w;
    w = $clog2(hold_cycles + 1);
    return (w < CNT_W_MIN) ? CNT_W_MIN : w;
  endfunction

endpackage

// File: rtl/dec_hold_counter.sv
// rtl/dec_hold_counter.sv - load / decrement / zero-flag down-counter timing each held one-hot word
module dec_hold_counter
  import dec_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturates at zero so it can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/priority_decoder_seq.sv
// rtl/priority_decoder_seq.sv - registered index-to-one-hot decoder with valid/ready input and hold timer
// Optional range check (err port) enabled by macro DEC_RANGE_CHECK_EN.
module priority_decoder_seq
  import dec_pkg::*;
#(
  parameter int IDX_W       = 3,
  parameter int OUT_W       = 8,
  parameter int HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] idx,
  output logic [OUT_W-1:0] y,
  output logic             y_valid,
  output logic             busy
`ifdef DEC_RANGE_CHECK_EN
  ,
  output logic             err
`endif
);

  state_e           state_q;
  logic [OUT_W-1:0] y_q;
  logic [OUT_W-1:0] y_d;
  logic             y_valid_q;
  logic             busy_q;
  logic             cnt_zero;
  logic             accept;
  logic             drop;

  assign in_ready = enable && ((state_q == IDLE) || cnt_zero);
  assign accept   = in_valid && in_ready;
  // An index past the top output line shifts out to an all-zero word.
  assign y_d      = OUT_W'(1) << idx;

`ifdef DEC_RANGE_CHECK_EN
  logic err_q;

  assign drop = (int'(idx) >= OUT_W);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && drop;
    end
  end

  assign err = err_q;
`else
  assign drop = 1'b0;
`endif

  dec_hold_counter #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(accept && !drop),
    .dec_i (state_q == HOLD),
    .zero_o(cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else if (accept && !drop) begin
      state_q   <= HOLD;
      y_q       <= y_d;
      y_valid_q <= 1'b1;
      busy_q    <= 1'b1;
    end else if (accept || ((state_q == HOLD) && (!enable || cnt_zero))) begin
      state_q   <= IDLE;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_priority_decoder_seq.sv
// tb/tb_priority_decoder_seq.sv - self-checking bench for priority_decoder_seq (honours DEC_RANGE_CHECK_EN)
module tb_priority_decoder_seq;

  logic       clk = 1'b0;
  logic       rst_n, enable, in_valid;
  logic [2:0] idx;

  logic       rdy0, rdy1, rdy2;
  logic [7:0] y0, y1;
  logic [5:0] y2;
  logic       yv0, yv1, yv2, bz0, bz1, bz2;
`ifdef DEC_RANGE_CHECK_EN
  logic       er0, er1, er2;
  localparam bit RC = 1'b1;
`else
  logic       er0 = 1'b0, er1 = 1'b0, er2 = 1'b0;
  localparam bit RC = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  priority_decoder_seq #(.IDX_W(3), .OUT_W(8), .HOLD_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(rdy0),
    .idx(idx), .y(y0), .y_valid(yv0), .busy(bz0)
`ifdef DEC_RANGE_CHECK_EN
    , .err(er0)
`endif
  );

  priority_decoder_seq #(.IDX_W(3), .OUT_W(8), .HOLD_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(rdy1),
    .idx(idx), .y(y1), .y_valid(yv1), .busy(bz1)
`ifdef DEC_RANGE_CHECK_EN
    , .err(er1)
`endif
  );

  priority_decoder_seq #(.IDX_W(3), .OUT_W(6), .HOLD_CYCLES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(rdy2),
    .idx(idx), .y(y2), .y_valid(yv2), .busy(bz2)
`ifdef DEC_RANGE_CHECK_EN
    , .err(er2)
`endif
  );

  // Reference model: per instance, cycles of visible output left and the word shown.
  int         hc[3] = '{1, 3, 1};
  int         ow[3] = '{8, 8, 6};
  int         rem[3];
  logic [7:0] word[3];
  bit         err_m[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ready(input int d);
    return enable && (rem[d] <= 1);
  endfunction

  task automatic model_edge();
    bit acc[3];
    for (int d = 0; d < 3; d++) acc[d] = in_valid && exp_ready(d);
    for (int d = 0; d < 3; d++) begin
      err_m[d] = 1'b0;
      if (!rst_n) begin
        rem[d] = 0;
      end else if (acc[d]) begin
        if (RC && (int'(idx) >= ow[d])) begin
          rem[d]   = 0;
          err_m[d] = 1'b1;
        end else begin
          rem[d]  = hc[d];
          word[d] = (int'(idx) < ow[d]) ? 8'(2 ** int'(idx)) : 8'd0;
        end
      end else if (!enable) begin
        rem[d] = 0;
      end else if (rem[d] > 0) begin
        rem[d] = rem[d] - 1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("y0",  y0,  (rem[0] > 0) ? word[0] : 8'd0);
    chk("yv0", yv0, rem[0] > 0);
    chk("bz0", bz0, rem[0] > 0);
    chk("y1",  y1,  (rem[1] > 0) ? word[1] : 8'd0);
    chk("yv1", yv1, rem[1] > 0);
    chk("bz1", bz1, rem[1] > 0);
    chk("y2",  y2,  (rem[2] > 0) ? word[2] : 8'd0);
    chk("yv2", yv2, rem[2] > 0);
    chk("bz2", bz2, rem[2] > 0);
    if (RC) begin
      chk("er0", er0, err_m[0]);
      chk("er1", er1, err_m[1]);
      chk("er2", er2, err_m[2]);
    end
  endtask

  // Drive one cycle of inputs, check in_ready before the edge and outputs after it.
  task automatic step(input logic r, input logic e, input logic v, input logic [2:0] i);
    rst_n = r; enable = e; in_valid = v; idx = i;
    #1;
    chk("rdy0", rdy0, exp_ready(0));
    chk("rdy1", rdy1, exp_ready(1));
    chk("rdy2", rdy2, exp_ready(2));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; idx = 3'd0;
    for (int d = 0; d < 3; d++) begin rem[d] = 0; word[d] = 8'd0; err_m[d] = 1'b0; end
    @(negedge clk);

    step(0, 0, 0, 0);
    step(0, 1, 1, 5);
    chk("rst_y0", y0, 8'h00);
    chk("rst_yv1", yv1, 1'b0);

    step(1, 1, 1, 3);
    chk("idx3_y0", y0, 8'b0000_1000);
    chk("idx3_yv0", yv0, 1'b1);
    step(1, 1, 0, 3);
    chk("idx3_off_y0", y0, 8'h00);

    step(1, 1, 1, 6);
    chk("s6_y0", y0, 8'b0100_0000);
    step(1, 1, 1, 5);
    chk("s5_y0", y0, 8'b0010_0000);
    step(1, 1, 1, 4);
    chk("s4_y0", y0, 8'b0001_0000);
    for (int k = 0; k < 4; k++) step(1, 1, 0, 0);

    step(1, 1, 1, 7);
    chk("h3_y1_a", y1, 8'h80);
    chk("h3_rdy1_a", rdy1, 1'b0);
    step(1, 1, 0, 0);
    chk("h3_y1_b", y1, 8'h80);
    chk("h3_rdy1_b", rdy1, 1'b0);
    step(1, 1, 0, 0);
    chk("h3_y1_c", y1, 8'h80);
    chk("h3_rdy1_c", rdy1, 1'b1);
    step(1, 1, 0, 0);
    chk("h3_y1_d", y1, 8'h00);

    step(1, 1, 1, 2);
    chk("ab_y1", y1, 8'h04);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("ab_y1_off", y1, 8'h00);
    chk("ab_yv1", yv1, 1'b0);
    chk("ab_bz1", bz1, 1'b0);

    step(1, 1, 1, 1);
    chk("rm_y1", y1, 8'h02);
    step(0, 1, 0, 0);
    chk("rm_y1_rst", y1, 8'h00);
    chk("rm_yv1_rst", yv1, 1'b0);
    chk("rm_rdy1", rdy1, 1'b1);
    for (int k = 0; k < 3; k++) step(1, 1, 0, 0);

    step(1, 1, 1, 7);
    if (RC) begin
      chk("rg_err2", er2, 1'b1);
      chk("rg_yv2", yv2, 1'b0);
    end else begin
      chk("rg_yv2", yv2, 1'b1);
      chk("rg_y2", y2, 6'd0);
    end
    step(1, 1, 0, 0);
    if (RC) chk("rg_err2_clr", er2, 1'b0);

    for (int k = 0; k < 400; k++) begin
      step(($urandom % 64) != 0, ($urandom % 8) != 0, $urandom % 3 != 0, 3'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
